// File: rtl/sdram_init_refresh.sv
// rtl/sdram_init_refresh.sv - SDRAM power-up init sequencer and periodic auto-refresh arbiter
module sdram_init_refresh #(
    parameter int          T_INIT         = 10000,
    parameter int          T_RP           = 2,
    parameter int          T_RFC          = 7,
    parameter int          T_MRD          = 2,
    parameter int          INIT_REF_COUNT = 8,
    parameter int          REF_INTERVAL   = 780,
    parameter logic [12:0] MODE_REG       = 13'h020
) (
    input  logic        SDRAM_CLK,
    input  logic        SDRAM_RST,
    output logic        INIT_DONE,
    output logic        REF_REQ,
    input  logic        REF_GNT,
    output logic        REF_DONE,
    output logic        REF_ERR,
    output logic        CMD_VALID,
    output logic        CMD_CKE,
    output logic        CMD_CSn,
    output logic        CMD_RASn,
    output logic        CMD_CASn,
    output logic        CMD_WEn,
    output logic [12:0] CMD_ADDR,
    output logic [1:0]  CMD_BA
);
    localparam int CW = $clog2(T_INIT + T_RP + T_RFC + T_MRD + 2);
    localparam int RW = $clog2(REF_INTERVAL + 1);
    localparam int IW = $clog2(INIT_REF_COUNT + 1);

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_PALL = 4'b0010;
    localparam logic [3:0] C_REF  = 4'b0001;
    localparam logic [3:0] C_MRS  = 4'b0000;

    typedef enum logic [2:0] {S_WAIT, S_I_PRE, S_I_REF, S_I_MRS, S_IDLE, S_PRE, S_REF} state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [IW-1:0] r_irefs, w_irefs_nx;
    logic [RW-1:0] r_timer, w_timer_nx;
    logic [3:0]    r_pending, w_pending_nx;
    logic [3:0]    r_cmd, w_cmd_nx;
    logic [12:0]   r_addr, w_addr_nx;
    logic          r_valid, w_valid_nx;
    logic          r_init_done, w_init_done_nx;
    logic          r_ref_req, w_ref_req_nx;
    logic          r_ref_done, w_ref_done_nx;
    logic          r_ref_err, w_ref_err_nx;
    logic          r_cke;
    logic [1:0]    r_ba;
    logic          w_issue;
    logic          w_tick;

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_irefs_nx     = r_irefs;
        w_cmd_nx       = C_NOP;
        w_addr_nx      = '0;
        w_valid_nx     = r_valid;
        w_init_done_nx = r_init_done;
        w_ref_done_nx  = 1'b0;
        w_issue        = 1'b0;
        case (r_state)
            // WAIT counts up from the reset value of zero; every other wait counts down
            S_WAIT: begin
                if (r_cnt == CW'(T_INIT)) begin
                    w_cmd_nx   = C_PALL;
                    w_addr_nx  = 13'h0400;
                    w_state_nx = S_I_PRE;
                    w_cnt_nx   = CW'(T_RP - 1);
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            S_I_PRE: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - CW'(1);
                end else begin
                    w_cmd_nx   = C_REF;
                    w_state_nx = S_I_REF;
                    w_cnt_nx   = CW'(T_RFC - 1);
                    w_irefs_nx = r_irefs + IW'(1);
                end
            end
            S_I_REF: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - CW'(1);
                end else if (r_irefs == IW'(INIT_REF_COUNT)) begin
                    w_cmd_nx   = C_MRS;
                    w_addr_nx  = MODE_REG;
                    w_state_nx = S_I_MRS;
                    w_cnt_nx   = CW'(T_MRD - 1);
                end else begin
                    w_cmd_nx   = C_REF;
                    w_cnt_nx   = CW'(T_RFC - 1);
                    w_irefs_nx = r_irefs + IW'(1);
                end
            end
            S_I_MRS: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - CW'(1);
                end else begin
                    w_state_nx     = S_IDLE;
                    w_valid_nx     = 1'b0;
                    w_init_done_nx = 1'b1;
                end
            end
            S_IDLE: begin
                if (r_ref_req && REF_GNT) begin
                    w_cmd_nx   = C_PALL;
                    w_addr_nx  = 13'h0400;
                    w_valid_nx = 1'b1;
                    w_state_nx = S_PRE;
                    w_cnt_nx   = CW'(T_RP - 1);
                end
            end
            S_PRE: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - CW'(1);
                end else begin
                    w_cmd_nx   = C_REF;
                    w_issue    = 1'b1;
                    w_state_nx = S_REF;
                    w_cnt_nx   = CW'(T_RFC - 1);
                end
            end
            S_REF: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - CW'(1);
                end else begin
                    w_state_nx    = S_IDLE;
                    w_valid_nx    = 1'b0;
                    w_ref_done_nx = 1'b1;
                end
            end
            default: w_state_nx = S_WAIT;
        endcase
    end

    // Timer is armed in the same cycle INIT_DONE rises so the first tick lands REF_INTERVAL cycles later
    assign w_tick = r_init_done && (r_timer == '0);

    always_comb begin
        w_timer_nx   = r_timer;
        w_pending_nx = r_pending;
        w_ref_err_nx = r_ref_err;
        if (w_init_done_nx && !r_init_done) begin
            w_timer_nx = RW'(REF_INTERVAL - 1);
        end else if (r_init_done) begin
            w_timer_nx = w_tick ? RW'(REF_INTERVAL - 1) : r_timer - RW'(1);
        end
        if (w_tick && !w_issue) begin
            if (r_pending == 4'd8) begin
                w_ref_err_nx = 1'b1;
            end else begin
                w_pending_nx = r_pending + 4'd1;
            end
        end else if (w_issue && !w_tick) begin
            w_pending_nx = r_pending - 4'd1;
        end
        w_ref_req_nx = (w_state_nx == S_IDLE) && (w_pending_nx != 4'd0);
    end

    always_ff @(posedge SDRAM_CLK) begin
        if (SDRAM_RST) begin
            r_state     <= S_WAIT;
            r_cnt       <= '0;
            r_irefs     <= '0;
            r_timer     <= '0;
            r_pending   <= '0;
            r_cmd       <= C_NOP;
            r_addr      <= '0;
            r_valid     <= 1'b1;
            r_init_done <= 1'b0;
            r_ref_req   <= 1'b0;
            r_ref_done  <= 1'b0;
            r_ref_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_irefs     <= w_irefs_nx;
            r_timer     <= w_timer_nx;
            r_pending   <= w_pending_nx;
            r_cmd       <= w_cmd_nx;
            r_addr      <= w_addr_nx;
            r_valid     <= w_valid_nx;
            r_init_done <= w_init_done_nx;
            r_ref_req   <= w_ref_req_nx;
            r_ref_done  <= w_ref_done_nx;
            r_ref_err   <= w_ref_err_nx;
        end
        r_cke <= 1'b1;
        r_ba  <= 2'b00;
    end

    assign INIT_DONE = r_init_done;
    assign REF_REQ   = r_ref_req;
    assign REF_DONE  = r_ref_done;
    assign REF_ERR   = r_ref_err;
    assign CMD_VALID = r_valid;
    assign CMD_CKE   = r_cke;
    assign {CMD_CSn, CMD_RASn, CMD_CASn, CMD_WEn} = r_cmd;
    assign CMD_ADDR  = r_addr;
    assign CMD_BA    = r_ba;
endmodule

// File: tb/tb_sdram_init_refresh.sv
// tb/tb_sdram_init_refresh.sv - directed self-checking bench for sdram_init_refresh
module tb_sdram_init_refresh;
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_PALL = 4'b0010;
    localparam logic [3:0] C_REF  = 4'b0001;
    localparam logic [3:0] C_MRS  = 4'b0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gnt = 1'b0;
    logic        init_done, ref_req, ref_done, ref_err, cmd_valid, cke;
    logic        csn, rasn, casn, wen;
    logic [12:0] addr;
    logic [1:0]  ba;
    wire  [3:0]  w_cmd = {csn, rasn, casn, wen};
    wire  [24:0] w_obs = {w_cmd, addr, ba, cmd_valid, init_done, cke, ref_req, ref_done, ref_err};

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    sdram_init_refresh #(
        .T_INIT(20), .T_RP(2), .T_RFC(4), .T_MRD(2),
        .INIT_REF_COUNT(2), .REF_INTERVAL(50), .MODE_REG(13'h020)
    ) dut (
        .SDRAM_CLK(clk), .SDRAM_RST(rst), .INIT_DONE(init_done), .REF_REQ(ref_req),
        .REF_GNT(gnt), .REF_DONE(ref_done), .REF_ERR(ref_err), .CMD_VALID(cmd_valid),
        .CMD_CKE(cke), .CMD_CSn(csn), .CMD_RASn(rasn), .CMD_CASn(casn), .CMD_WEn(wen),
        .CMD_ADDR(addr), .CMD_BA(ba)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        gnt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        gnt = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (w_cmd !== C_NOP || cke !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd got cmd=%b cke=%b exp cmd=0111 cke=1", w_cmd, cke);
        end
        n_cmp++;
        if (cmd_valid !== 1'b1 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got valid=%b init_done=%b exp valid=1 init_done=0", cmd_valid, init_done);
        end
        n_cmp++;
        if ({ref_req, ref_done, ref_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ref got req/done/err=%b exp 000", {ref_req, ref_done, ref_err});
        end
        n_cmp++;
        if (addr !== 13'h0 || ba !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_addr got addr=%h ba=%h exp 0 0", addr, ba);
        end
        rst = 1'b0;
        gnt = 1'b0;
        cyc = -1;
    endtask

    task automatic test_init();
        logic [3:0]  e_cmd;
        logic [12:0] e_addr;
        logic [24:0] exp;
        while (cyc < 33) begin
            step();
            e_cmd  = C_NOP;
            e_addr = 13'h0;
            if (cyc == 20) begin e_cmd = C_PALL; e_addr = 13'h0400; end
            if (cyc == 22 || cyc == 26) e_cmd = C_REF;
            if (cyc == 30) begin e_cmd = C_MRS; e_addr = 13'h0020; end
            exp = {e_cmd, e_addr, 2'b00, (cyc < 32), (cyc >= 32), 1'b1, 3'b000};
            n_cmp++;
            if (w_obs !== exp) begin
                n_fail++;
                $display("FAIL init cyc=%0d got=%h exp=%h", cyc, w_obs, exp);
            end
        end
    endtask

    task automatic test_refresh();
        logic [3:0]  e_cmd;
        logic [12:0] e_addr;
        logic [24:0] exp;
        gnt = 1'b1;
        while (cyc < 100) begin
            step();
            e_cmd  = C_NOP;
            e_addr = 13'h0;
            if (cyc == 83) begin e_cmd = C_PALL; e_addr = 13'h0400; end
            if (cyc == 85) e_cmd = C_REF;
            exp = {e_cmd, e_addr, 2'b00, (cyc >= 83 && cyc <= 88), 1'b1, 1'b1,
                   (cyc == 82), (cyc == 89), 1'b0};
            n_cmp++;
            if (w_obs !== exp) begin
                n_fail++;
                $display("FAIL refresh cyc=%0d got=%h exp=%h", cyc, w_obs, exp);
            end
        end
        gnt = 1'b0;
    endtask

    task automatic test_tick_during_refresh();
        do_reset();
        while (cyc < 140) begin
            step();
            if (cyc == 130 || cyc == 132) begin
                n_cmp++;
                if (w_cmd !== ((cyc == 130) ? C_PALL : C_REF)) begin
                    n_fail++;
                    $display("FAIL tick_cmd cyc=%0d got=%b", cyc, w_cmd);
                end
            end
            if (cyc == 135) begin
                n_cmp++;
                if (ref_req !== 1'b0 || ref_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tick_busy got req=%b done=%b exp 0 0", ref_req, ref_done);
                end
            end
            if (cyc == 136) begin
                n_cmp++;
                if (ref_req !== 1'b1 || ref_done !== 1'b1 || cmd_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tick_pending got req=%b done=%b valid=%b exp 1 1 0", ref_req, ref_done, cmd_valid);
                end
            end
            gnt = (cyc == 129);
        end
        gnt = 1'b0;
    endtask

    task automatic test_starvation();
        int n_ref  = 0;
        int n_done = 0;
        do_reset();
        while (cyc < 482) begin
            step();
            if (cyc == 300 || cyc == 481) begin
                n_cmp++;
                if (ref_req !== 1'b1 || ref_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL starve_pre cyc=%0d got req=%b err=%b exp 1 0", cyc, ref_req, ref_err);
                end
            end
        end
        n_cmp++;
        if (ref_err !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_err got=%b exp=1", ref_err);
        end
        gnt = 1'b1;
        while (cyc < 580) begin
            step();
            if (w_cmd === C_REF) n_ref++;
            if (ref_done === 1'b1) n_done++;
            if (cyc == 538) begin
                n_cmp++;
                if (n_ref != 8 || ref_req !== 1'b1) begin
                    n_fail++;
                    $display("FAIL starve_eight got refs=%0d req=%b exp 8 1", n_ref, ref_req);
                end
            end
        end
        n_cmp++;
        if (n_ref != 9 || n_done != 9) begin
            n_fail++;
            $display("FAIL starve_count got refs=%0d dones=%0d exp 9 9", n_ref, n_done);
        end
        n_cmp++;
        if (ref_req !== 1'b0 || ref_err !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_end got req=%b err=%b exp 0 1", ref_req, ref_err);
        end
        gnt = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [24:0] exp;
        do_reset();
        gnt = 1'b1;
        while (cyc < 86) step();
        n_cmp++;
        if (w_cmd !== C_NOP || cmd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_gap got cmd=%b valid=%b exp 0111 1", w_cmd, cmd_valid);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (w_obs !== {C_NOP, 13'h0, 2'b00, 1'b1, 1'b0, 1'b1, 3'b000}) begin
            n_fail++;
            $display("FAIL mid_reset got=%h exp=%h", w_obs, {C_NOP, 13'h0, 2'b00, 1'b1, 1'b0, 1'b1, 3'b000});
        end
        rst = 1'b0;
        cyc = -1;
        while (cyc < 21) begin
            step();
            exp = {(cyc == 20) ? C_PALL : C_NOP, (cyc == 20) ? 13'h0400 : 13'h0, 2'b00,
                   1'b1, 1'b0, 1'b1, 3'b000};
            n_cmp++;
            if (w_obs !== exp) begin
                n_fail++;
                $display("FAIL mid_restart cyc=%0d got=%h exp=%h", cyc, w_obs, exp);
            end
        end
        gnt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init();
        test_refresh();
        test_tick_during_refresh();
        test_starvation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
